// File: rtl/mem_sequencer_pkg.sv
// Shared control types for the memory block and its sequencer.
// Op and bus encodings follow the memory block's own decode.
package control;

    typedef enum logic [2:0] {
        NOP,
        READ,
        WRITE,
        INC,
        ABSOLUTE,
        REL_ADD,
        REL_SUB
    } memory_op_e;

    typedef enum logic {
        MAR = 1'b0,
        PC  = 1'b1
    } memory_bus_selector_e;

    typedef enum logic [2:0] {
        LOAD,
        STORE,
        JUMP,
        BR_FWD,
        BR_BACK
    } mem_cmd_e;

    typedef enum logic [3:0] {
        IDLE,
        F_RD0A,
        F_RD0B,
        F_RD1A,
        F_RD1B,
        F_INC,
        D_ADDR,
        D_RDA,
        D_RDB,
        D_WR,
        D_PC
    } mem_seq_state_e;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_DATA
    } grant_e;

    function automatic logic is_mem_access(input mem_cmd_e c);
        return (c == LOAD) || (c == STORE);
    endfunction

    function automatic memory_op_e pc_op(input mem_cmd_e c);
        memory_op_e op;
        op = ABSOLUTE;
        unique case (c)
            BR_FWD:  op = REL_ADD;
            BR_BACK: op = REL_SUB;
            default: op = ABSOLUTE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_sequencer.sv
// Round-robin sequencer sharing the memory block between
// instruction fetch and the execute stage's data/PC commands.
module mem_sequencer
    import control::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_req,
    output logic                 fetch_done,
    output logic [15:0]          instr,
    input  logic                 data_req,
    input  mem_cmd_e             data_cmd,
    input  logic [7:0]           data_addr,
    input  logic                 data_dws,
    input  logic [7:0]           data_wdata,
    output logic                 data_done,
    output logic [7:0]           data_rdata,
    output memory_op_e           mem_op,
    output memory_bus_selector_e mem_bus_sel,
    output logic                 mem_dws,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
);

    mem_seq_state_e state, state_next;
    grant_e         last_grant;
    mem_cmd_e       cmd_q;
    logic [7:0]     addr_q;
    logic [7:0]     wdata_q;
    logic           dws_q;
    logic           grant_f;
    logic           grant_d;

    always_comb begin
        grant_f = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            unique case (1'b1)
                fetch_req && !data_req: grant_f = 1'b1;
                data_req && !fetch_req: grant_d = 1'b1;
                fetch_req && data_req: begin
                    grant_f = (last_grant == GRANT_DATA);
                    grant_d = (last_grant == GRANT_FETCH);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        mem_op      = NOP;
        mem_bus_sel = MAR;
        mem_dws     = 1'b0;
        mem_wdata   = 8'h00;
        unique case (state)
            IDLE: begin
                if (grant_f)
                    state_next = F_RD0A;
                else if (grant_d)
                    state_next = is_mem_access(data_cmd)
                               ? D_ADDR : D_PC;
            end
            F_RD0A, F_RD0B: begin
                mem_op      = READ;
                mem_bus_sel = PC;
                state_next  = (state == F_RD0A) ? F_RD0B : F_RD1A;
            end
            F_RD1A, F_RD1B: begin
                mem_op      = READ;
                mem_bus_sel = PC;
                mem_dws     = 1'b1;
                state_next  = (state == F_RD1A) ? F_RD1B : F_INC;
            end
            F_INC: begin
                mem_op      = INC;
                mem_bus_sel = PC;
                state_next  = IDLE;
            end
            D_ADDR: begin
                mem_op     = ABSOLUTE;
                mem_wdata  = addr_q;
                state_next = (cmd_q == STORE) ? D_WR : D_RDA;
            end
            D_RDA, D_RDB: begin
                mem_op     = READ;
                mem_dws    = dws_q;
                state_next = (state == D_RDA) ? D_RDB : IDLE;
            end
            D_WR: begin
                mem_op     = WRITE;
                mem_dws    = dws_q;
                mem_wdata  = wdata_q;
                state_next = IDLE;
            end
            D_PC: begin
                mem_op      = pc_op(cmd_q);
                mem_bus_sel = PC;
                mem_wdata   = addr_q;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command operands are latched at grant so a dropped request
    // cannot disturb an operation already in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_DATA;
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            instr      <= 16'h0000;
            data_rdata <= 8'h00;
            cmd_q      <= LOAD;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            dws_q      <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_done <= (state == F_INC);
            data_done  <= (state == D_RDB) || (state == D_WR)
                       || (state == D_PC);
            if (grant_f)
                last_grant <= GRANT_FETCH;
            if (grant_d) begin
                last_grant <= GRANT_DATA;
                cmd_q      <= data_cmd;
                addr_q     <= data_addr;
                wdata_q    <= data_wdata;
                dws_q      <= data_dws;
            end
            if (state == F_RD0B)
                instr[15:8] <= mem_rdata;
            if (state == F_RD1B)
                instr[7:0] <= mem_rdata;
            if (state == D_RDB)
                data_rdata <= mem_rdata;
        end
    end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Controller that sequences the `memory` block: it owns the `op`, `bus_selector`, `data_word_selector` and `in` lines of `memory` and accepts `out` from it. It shares `memory` between two requesters:
- the instruction fetch unit, which reads a 16-bit instruction word at PC and advances PC;
- the execute stage, which issues loads and stores through MAR and updates PC for jumps and branches.

Arbitration is round-robin between the two ports. Every granted operation runs to completion.

## Interface
Parameters: none. Address width comes from `` `ADDR_BUS_WIDTH `` inside `memory`; all operands here are 8 bits.

- `clock`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high.
- `fetch_req`  in  1  fetch request; level, held until `fetch_done`.
- `fetch_done`  out  1  one-cycle pulse: `instr` updated.
- `instr`  out  16  last fetched word, `{byte@dws0, byte@dws1}`; held between fetches.
- `data_req`  in  1  data request; level, held until `data_done`.
- `data_cmd`  in  `mem_cmd_e`  LOAD, STORE, JUMP, BR_FWD, BR_BACK; stable while `data_req` is high.
- `data_addr`  in  8  address for LOAD/STORE; target or offset for JUMP/BR_*.
- `data_dws`  in  1  data word selector for LOAD/STORE.
- `data_wdata`  in  8  STORE data.
- `data_done`  out  1  one-cycle pulse: data command complete.
- `data_rdata`  out  8  LOAD result; held until the next LOAD.
- `mem_op`  out  `memory_op_e`  drives `memory.op`.
- `mem_bus_sel`  out  `memory_bus_selector_e`  drives `memory.bus_selector`; MAR=0, PC=1.
- `mem_dws`  out  1  drives `memory.data_word_selector`.
- `mem_wdata`  out  8  drives `memory.in`.
- `mem_rdata`  in  8  from `memory.out`.

## Operation
- **States:** IDLE, F_RD0A, F_RD0B, F_RD1A, F_RD1B, F_INC, D_ADDR, D_RDA, D_RDB, D_WR, D_PC.
- **IDLE:** drives `mem_op`=NOP, `mem_bus_sel`=MAR, `mem_dws`=0, `mem_wdata`=0. At the posedge it samples the requests:
  - neither high: stay in IDLE;
  - one high: grant it;
  - both high: grant the port not granted last. The `last_grant` flag resets to DATA, so fetch wins the first tie.
- **Fetch sequence:**
  - F_RD0A: READ, PC, dws=0.
  - F_RD0B: same drives; `instr[15:8]` captured at the end of the cycle.
  - F_RD1A: READ, PC, dws=1.
  - F_RD1B: same drives; `instr[7:0]` captured at the end of the cycle.
  - F_INC: INC, PC.
  - Then IDLE with `fetch_done`=1.
- **Why reads take two cycles:** `memory` registers read data at the posedge and drives `out` only while `op`==READ. READ is therefore held for two cycles and data is sampled at the end of the second.
- **LOAD:**
  - D_ADDR: ABSOLUTE, MAR, `mem_wdata`=`data_addr`.
  - D_RDA, D_RDB: READ, MAR, dws=`data_dws`; `data_rdata` captured at the end of D_RDB.
  - Then IDLE with `data_done`.
- **STORE:**
  - D_ADDR as for LOAD.
  - D_WR: WRITE, MAR, dws=`data_dws`, `mem_wdata`=`data_wdata`. The write lands on the negedge within D_WR.
  - Then IDLE with `data_done`.
- **JUMP / BR_FWD / BR_BACK:** D_PC drives ABSOLUTE / REL_ADD / REL_SUB respectively, with PC selected and `mem_wdata`=`data_addr`. Then IDLE with `data_done`.
- **Arithmetic:** PC wrap-around is `memory`'s modulo arithmetic. The sequencer performs no range checks.
- **Done pulses:** asserted only in the IDLE cycle following completion. A request still high at the end of that cycle is treated as a new request. Requesters drop `req` in the `done` cycle to avoid a repeat.
- **Request drop before grant:** a request withdrawn before it is granted is ignored. A request withdrawn after grant does not abort the operation.

## Timing
- **Reset values:**
  - state IDLE, `last_grant`=DATA;
  - `fetch_done`=0, `data_done`=0;
  - `instr`=0, `data_rdata`=0;
  - mem drives as in IDLE.
- **Latency** (IDLE sample edge to the `done` cycle, inclusive of IDLE return):
  - fetch 6 cycles;
  - LOAD 4;
  - STORE 3;
  - JUMP/BR 2.
- **Reset mid-operation:** next state is IDLE, no `done` pulse, `instr`/`data_rdata` cleared. A partial fetch never updates PC.
- **Back-to-back:** with both ports continuously requesting, grants alternate F, D, F, D. There is no idle cycle other than the mandatory IDLE/`done` cycle.
- **Output registration:** all outputs except `mem_*` are registered. `mem_*` are decoded from state, so they are glitch-free per cycle.

## Structure
- Add `mem_cmd_e` to package `control`, alongside the existing `memory_op_e` and `memory_bus_selector_e`. Also add there the state enum `mem_seq_state_e` and the grant enum `{GRANT_FETCH, GRANT_DATA}`.
- The NOP value of `memory_op_e` is the idle drive.
- The design is a single module, no sub-module. Benches instantiate `mem_sequencer` with the real `memory`.

## Test plan
1. Reset, preload cells[0]=0x12 and cells[1]=0x34, then pulse `fetch_req` → `fetch_done` 6 cycles later, `instr`=0x1234. A second fetch reads cells[2..3], proving PC=1.
2. STORE addr=0x05, dws=1, data=0xA5, then LOAD addr=0x05, dws=1 → `data_done` after 3 and 4 cycles respectively, `data_rdata`=0xA5. Cell {0x05,0} is unchanged.
3. `fetch_req` and `data_req` both raised in the same cycle after reset → fetch granted first, data next. Grant order F, D, F, D under continuous requests.
4. JUMP 0x10, then BR_BACK 0x03, then fetch → the fetch reads cells {0x0D,0} and {0x0D,1}.
5. Reset asserted during F_RD1B → no `fetch_done`, `instr`=0. PC=0 afterwards: the next fetch returns the cells at 0.
6. `data_req` held high through `data_done` with STORE → the store repeats, and the second `data_done` comes 3 cycles after the first.
